// File: rtl/interrupt_sequencer_pkg.sv
// rtl/interrupt_sequencer_pkg.sv - shared CP0 interrupt constants, state encoding and priority helper
package interrupt_sequencer_pkg;

    // Cause.IP field geometry
    localparam int IP_WIDTH = 6;
    localparam int IP_BASE  = 10;

    // ExcCode submitted to CP0 for an external interrupt
    localparam logic [4:0] EXC_CODE_INT = 5'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        TAKEN   = 2'd2
    } irq_state_t;

    // Highest set index of v (bit 5 highest); 0 when nothing is set
    function automatic logic [2:0] irq_prio_idx(input logic [IP_WIDTH-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < IP_WIDTH; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_irq_synchronizer.sv
// rtl/interrupt_sequencer_irq_synchronizer.sv - hw_irq synchronizer chain and pending-bit capture (IRQ_EDGE_TRIGGER_EN selects edge mode)
module irq_synchronizer
    import interrupt_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [IP_WIDTH-1:0] hw_irq,
    input  logic [IP_WIDTH-1:0] ip_clr,
    output logic [IP_WIDTH-1:0] ip
);

    logic [IP_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [IP_WIDTH-1:0] w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Shift each request line through the synchronizer chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= hw_irq;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

`ifdef IRQ_EDGE_TRIGGER_EN
    logic [IP_WIDTH-1:0] r_prev;
    logic [IP_WIDTH-1:0] r_ip;
    logic [IP_WIDTH-1:0] w_rise;

    assign w_rise = w_sync & ~r_prev;
    // A rising edge is visible on ip in the cycle it is detected, so edge
    // and level modes share the same SYNC_STAGES latency.
    assign ip     = r_ip | w_rise;

    // Latch rising edges; a software clear beats a same-cycle edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
            r_ip   <= '0;
        end else begin
            r_prev <= w_sync;
            r_ip   <= (r_ip | w_rise) & ~ip_clr;
        end
    end
`else
    logic w_unused_ip_clr;

    // Level mode: pending tracks the synchronized line, clears have no effect
    assign w_unused_ip_clr = ^ip_clr;
    assign ip              = w_sync;
`endif

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - CP0 interrupt sequencer: enable, priority, take FSM and stall counter (IRQ_EDGE_TRIGGER_EN)
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_WAIT    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [IP_WIDTH-1:0] hw_irq,
    input  logic [IP_WIDTH-1:0] sr_im,
    input  logic                sr_ie,
    input  logic                sr_exl,
    input  logic                commit_valid,
    input  logic                exception,
    input  logic                eret,
    input  logic [IP_WIDTH-1:0] ip_clr,
    output logic [IP_WIDTH-1:0] ip,
    output logic                irq_take,
    output logic [2:0]          irq_id,
    output logic                irq_stall,
    output logic                busy
);

    localparam int WAIT_W = $clog2(MAX_WAIT) + 1;

    irq_state_t          r_state;
    irq_state_t          w_next;
    logic [WAIT_W-1:0]   r_wait;
    logic [IP_WIDTH-1:0] w_ip;
    logic [IP_WIDTH-1:0] w_masked;
    logic                w_enable;

    irq_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .hw_irq  (hw_irq),
        .ip_clr  (ip_clr),
        .ip      (w_ip)
    );

    assign w_masked  = w_ip & sr_im;
    assign w_enable  = (|w_masked) & sr_ie & ~sr_exl;
    assign ip        = w_ip;
    assign irq_id    = irq_prio_idx(w_masked);
    assign busy      = (r_state != IDLE);
    assign irq_stall = (r_state == PENDING) && (r_wait >= WAIT_W'(MAX_WAIT - 1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next state and take pulse; an exception at the commit point beats the interrupt
    always_comb begin
        w_next   = r_state;
        irq_take = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_enable) w_next = PENDING;
            end
            PENDING: begin
                if (!w_enable) begin
                    w_next = IDLE;
                end else if (commit_valid && !exception) begin
                    irq_take = 1'b1;
                    w_next   = TAKEN;
                end
            end
            TAKEN: begin
                if (eret) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Saturating wait counter: counts PENDING cycles, cleared on any exit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait <= '0;
        end else if (r_state == PENDING && w_next == PENDING) begin
            if (r_wait != '1) r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - directed self-checking bench for interrupt_sequencer
module tb_interrupt_sequencer;
    import interrupt_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] hw_irq, sr_im, ip_clr, ip;
    logic       sr_ie, sr_exl, commit_valid, exception, eret;
    logic       irq_take, irq_stall, busy;
    logic [2:0] irq_id;

    int n_checks = 0;
    int n_pass   = 0;

    interrupt_sequencer #(.SYNC_STAGES(2), .MAX_WAIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .hw_irq(hw_irq), .sr_im(sr_im),
        .sr_ie(sr_ie), .sr_exl(sr_exl), .commit_valid(commit_valid),
        .exception(exception), .eret(eret), .ip_clr(ip_clr), .ip(ip),
        .irq_take(irq_take), .irq_id(irq_id), .irq_stall(irq_stall), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; hw_irq = '0; sr_im = '0; ip_clr = '0;
        sr_ie = 1'b0; sr_exl = 1'b0; commit_valid = 1'b0; exception = 1'b0; eret = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic enable_all();
        sr_im = 6'h3F; sr_ie = 1'b1; sr_exl = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ip !== 6'h00) $display("FAIL reset_ip: got %h expected 00", ip); else n_pass++;
        n_checks++; if ({irq_take, irq_stall, irq_id} !== 5'b0) $display("FAIL reset_outs: got %b expected 00000", {irq_take, irq_stall, irq_id}); else n_pass++;
    endtask

    task automatic test_take();
        do_reset();
        enable_all();
        hw_irq = 6'h04;             // cycle 0
        tick(); tick();             // cycle 2
        n_checks++; if (ip !== 6'h04) $display("FAIL take_ip_c2: got %h expected 04", ip); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL take_idle_c2: got %b expected 0", busy); else n_pass++;
        tick();                     // cycle 3
        n_checks++; if (dut.r_state !== PENDING) $display("FAIL take_pending_c3: got %0d expected %0d", dut.r_state, PENDING); else n_pass++;
        commit_valid = 1'b1;
        #1;
        n_checks++; if (irq_take !== 1'b1) $display("FAIL take_pulse: got %b expected 1", irq_take); else n_pass++;
        n_checks++; if (irq_id !== 3'd2) $display("FAIL take_id: got %0d expected 2", irq_id); else n_pass++;
        tick();
        n_checks++; if (dut.r_state !== TAKEN) $display("FAIL take_taken: got %0d expected %0d", dut.r_state, TAKEN); else n_pass++;
        n_checks++; if (irq_take !== 1'b0) $display("FAIL take_single_pulse: got %b expected 0", irq_take); else n_pass++;
        commit_valid = 1'b0;
        hw_irq = 6'h0C;             // changes in TAKEN only move ip
        tick(); tick(); tick();
        n_checks++; if (ip !== 6'h0C || irq_take !== 1'b0) $display("FAIL taken_ip_update: got ip=%h take=%b expected ip=0c take=0", ip, irq_take); else n_pass++;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_checks++; if (dut.r_state !== IDLE) $display("FAIL eret_idle: got %0d expected %0d", dut.r_state, IDLE); else n_pass++;
        tick();
        n_checks++; if (dut.r_state !== PENDING) $display("FAIL eret_repend: got %0d expected %0d", dut.r_state, PENDING); else n_pass++;
    endtask

    task automatic test_priority_exception();
        do_reset();
        enable_all();
        hw_irq = 6'h21;
        tick(); tick(); tick();
        n_checks++; if (irq_id !== 3'd5) $display("FAIL prio_id: got %0d expected 5", irq_id); else n_pass++;
        commit_valid = 1'b1; exception = 1'b1;
        #1;
        n_checks++; if (irq_take !== 1'b0) $display("FAIL exc_wins: got %b expected 0", irq_take); else n_pass++;
        tick();
        n_checks++; if (dut.r_state !== PENDING) $display("FAIL exc_stay_pending: got %0d expected %0d", dut.r_state, PENDING); else n_pass++;
        exception = 1'b0;
        #1;
        n_checks++; if (irq_take !== 1'b1) $display("FAIL exc_then_take: got %b expected 1", irq_take); else n_pass++;
        tick();
        n_checks++; if (irq_take !== 1'b0) $display("FAIL no_back_to_back: got %b expected 0", irq_take); else n_pass++;
        commit_valid = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        enable_all();
        hw_irq = 6'h01;
        tick(); tick(); tick();     // first PENDING cycle
        for (int c = 1; c <= 7; c++) begin
            n_checks++; if (irq_stall !== 1'b0) $display("FAIL stall_early_c%0d: got %b expected 0", c, irq_stall); else n_pass++;
            tick();
        end
        n_checks++; if (irq_stall !== 1'b1) $display("FAIL stall_c8: got %b expected 1", irq_stall); else n_pass++;
        repeat (22) tick();         // PENDING cycle 30, counter saturated
        n_checks++; if (dut.r_wait !== 4'd15) $display("FAIL wait_saturate: got %0d expected 15", dut.r_wait); else n_pass++;
        n_checks++; if (irq_stall !== 1'b1) $display("FAIL stall_hold: got %b expected 1", irq_stall); else n_pass++;
        commit_valid = 1'b1;
        #1;
        n_checks++; if (irq_take !== 1'b1) $display("FAIL stall_take: got %b expected 1", irq_take); else n_pass++;
        tick();
        commit_valid = 1'b0;
        n_checks++; if (irq_stall !== 1'b0) $display("FAIL stall_release: got %b expected 0", irq_stall); else n_pass++;
    endtask

    task automatic test_mask_mid_wait();
        do_reset();
        enable_all();
        hw_irq = 6'h08;
        tick(); tick(); tick();
        repeat (9) tick();          // PENDING cycle 10, stalled
        n_checks++; if (irq_stall !== 1'b1) $display("FAIL mask_pre_stall: got %b expected 1", irq_stall); else n_pass++;
        sr_im = 6'h00;
        #1;
        n_checks++; if (irq_id !== 3'd0) $display("FAIL mask_id_zero: got %0d expected 0", irq_id); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0 || irq_stall !== 1'b0) $display("FAIL mask_idle: got busy=%b stall=%b expected 0 0", busy, irq_stall); else n_pass++;
        n_checks++; if (dut.r_wait !== 4'd0) $display("FAIL mask_wait_clear: got %0d expected 0", dut.r_wait); else n_pass++;
    endtask

    task automatic test_reset_in_taken();
        do_reset();
        enable_all();
        hw_irq = 6'h10;
        tick(); tick(); tick();
        commit_valid = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_pre_taken: got %b expected 1", busy); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if ({busy, irq_take, irq_stall, irq_id, ip} !== 12'h000) $display("FAIL rst_async_clear: got %h expected 000", {busy, irq_take, irq_stall, irq_id, ip}); else n_pass++;
        hw_irq = '0; commit_valid = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        n_checks++; if (ip !== 6'h00 || busy !== 1'b0) $display("FAIL rst_release: got ip=%h busy=%b expected 00 0", ip, busy); else n_pass++;
    endtask

`ifdef IRQ_EDGE_TRIGGER_EN
    task automatic test_edge_mode();
        do_reset();
        enable_all();
        hw_irq = 6'h01;
        tick();
        hw_irq = 6'h00;
        repeat (6) tick();
        n_checks++; if (ip[0] !== 1'b1) $display("FAIL edge_hold: got %b expected 1", ip[0]); else n_pass++;
        ip_clr = 6'h01;
        tick();
        ip_clr = 6'h00;
        n_checks++; if (ip[0] !== 1'b0) $display("FAIL edge_clear: got %b expected 0", ip[0]); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_take();
        test_priority_exception();
        test_stall();
        test_mask_mid_wait();
        test_reset_in_taken();
`ifdef IRQ_EDGE_TRIGGER_EN
        test_edge_mode();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
